stream_pattern_gen: RTL and testbench
=====================================

// Module: stream_pattern_gen
// PURPOSE
//  Generates a deterministic AXIS reference stream (per-lane counter, PRBS7 or PRBS31) that feeds one input of the
//  stream comparator. The DUT/loopback path feeds the other input. Full-rate AXIS source with backpressure support.
//  Sits directly upstream of the comparator. An IPIF register wrapper drives the cfg_* ports.
// PARAMETERS
//  TDATA_WIDTH  32  stream width; NLINKS = TDATA_WIDTH/32 independent 32-bit lanes (TDATA_WIDTH multiple of 32)
//  LANE_SEED_XOR 1  1: lane i seeds with cfg_seed ^ i; 0: all lanes share cfg_seed
// PORTS
//  clk             in   1            stream clock
//  aresetn         in   1            asynchronous active-low reset
//  cfg_start       in   1            pulse: load seeds and begin run
//  cfg_stop        in   1            pulse: end run after current beat is accepted
//  cfg_mode        in   2            0 counter, 1 PRBS7, 2 PRBS31, 3 fixed (cfg_seed repeated)
//  cfg_seed        in   32           initial lane state
//  cfg_burst_len   in   32           beats per run; 0 = continuous
//  cfg_inject_err  in   1            pulse: corrupt next beat (only with macro)
//  M_AXIS_TDATA    out  TDATA_WIDTH  pattern data
//  M_AXIS_TVALID   out  1            data valid
//  M_AXIS_TREADY   in   1            downstream ready
//  busy            out  1            high in RUN or DRAIN
//  beat_count      out  32           beats accepted in current/last run
// BEHAVIOUR
//  Reset (async, aresetn=0): state IDLE; TVALID=0, TDATA=0, busy=0, beat_count=0, lane states=0.
//  FSM IDLE -> RUN on cfg_start. Seeds load and beat_count clears. The first TVALID=1 comes exactly 1 cycle later.
//  RUN: TVALID held 1. A beat is accepted on TVALID&TREADY. After acceptance, all lanes advance one beat, beat_count+1,
//   and the new TDATA is registered the same edge (back-to-back beats at 1/cycle when TREADY=1).
//  Backpressure: while TVALID&!TREADY, TDATA, lane states and beat_count are frozen (AXIS stability rule).
//  RUN -> DRAIN when cfg_stop, or when (cfg_burst_len!=0 and the accepted beat is number cfg_burst_len).
//   A stop without a pending beat handshake keeps the current beat valid.
//   DRAIN: TVALID=1 until the current beat is accepted, then TVALID=0 -> IDLE. For a burst, the final beat has
//   already been accepted, so the burst goes RUN -> IDLE directly with TVALID=0 on the next edge.
//   Exactly cfg_burst_len beats are accepted.
//  cfg_start while busy is ignored. cfg_start and cfg_stop in the same cycle from IDLE: start wins, stop is ignored.
//  Counter mode: lane i = {i[7:0], n[23:0]}, where n = beat index (wraps 0xFFFFFF -> 0).
//  PRBS7 (x^7+x^6+1) / PRBS31 (x^31+x^28+1): each lane advances 32 bit-steps per beat.
//   TDATA lane bit 31 = first generated bit. An all-zero seed (after the XOR) is replaced by 1 to avoid lockup.
//   PRBS7 uses seed[6:0].
//  Fixed mode: every lane = lane seed, constant.
//  beat_count wraps 0xFFFFFFFF -> 0 silently in continuous mode. cfg_mode/cfg_seed changes during RUN are ignored
//   until the next cfg_start (latched at start).
//  aresetn asserted mid-beat: TVALID drops immediately (asynchronously). The downstream must tolerate this on reset only.
// CONFIGURATION
//  Macro STREAM_PATTERN_GEN_ERR_INJECT_EN:
//   defined: a cfg_inject_err pulse arms a flag. The next accepted beat in RUN/DRAIN has bit 0 of lane 0 inverted
//    (lane state is not corrupted, so later beats are clean). The flag clears on that acceptance.
//    A pulse in IDLE arms for the first beat of the next run.
//   undefined: cfg_inject_err is ignored (port kept, unused), and TDATA is always the pure pattern.
// STRUCTURE
//  Package stream_pattern_pkg: typedef enum logic[1:0] {PAT_COUNTER,PAT_PRBS7,PAT_PRBS31,PAT_FIXED} pat_mode_t;
//   FSM state enum {ST_IDLE,ST_RUN,ST_DRAIN}; functions prbs7_step32 and prbs31_step32 (32-step unrolled, pure).
//  Sub-module stream_pattern_lane: one 32-bit lane (state reg, mode mux, seed sanitise, advance enable).
//   Instantiated NLINKS times via a generate loop. The top holds the FSM, beat counter and inject logic.
// TESTING
//  Reset values: hold aresetn=0 -> TVALID=0, TDATA=0, busy=0, beat_count=0. Assert aresetn=0 mid-RUN -> all
//   return to these values immediately.
//  Counter, NLINKS=2, burst_len=4, TREADY=1 -> TDATA = 0x01000000_00000000, 0x01000001_00000001, ..._00000003;
//   then TVALID=0, beat_count=4, busy=0.
//  Backpressure: counter mode, TREADY low for 3 cycles on beat 2 -> TDATA is stable 0x..02 for 4 cycles and
//   beat_count is unchanged. The sequence resumes with no gap or duplicate.
//  PRBS31, seed 0, LANE_SEED_XOR=0 -> lane data bit-exact against a software LFSR seeded 1 over 1000 beats.
//   PRBS7 period check: word 127 = word 0.
//  Continuous run, cfg_stop asserted while TREADY=0 -> the pending beat stays valid until accepted, then TVALID=0
//   and the FSM returns to IDLE. A cfg_start during RUN has no effect.
//  With STREAM_PATTERN_GEN_ERR_INJECT_EN: inject on beat 5 -> only beat 5 differs from the model, in lane0 bit0.
//   Feeding the comparator gives err_count=1. Without the macro, err_count=0.

Source files
------------

// File: rtl/stream_pattern_pkg.sv
// -----------------------------------------------------------------------------
// stream_pattern_pkg
// Shared types and pure helper functions for the AXIS pattern generator.
//   pat_mode_t     : pattern selector (counter, PRBS7, PRBS31, fixed)
//   fsm_state_t    : generator FSM states
//   lane_step_t    : result of advancing one lane by one 32-bit beat
//   prbs7_step32   : 32 bit-steps of x^7+x^6+1 (Fibonacci form)
//   prbs31_step32  : 32 bit-steps of x^31+x^28+1 (Fibonacci form)
// In both LFSRs the newly generated bit shifts in at bit 0.
// The first generated bit of a beat lands in word bit 31.
// -----------------------------------------------------------------------------
package stream_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'd0,
        PAT_PRBS7   = 2'd1,
        PAT_PRBS31  = 2'd2,
        PAT_FIXED   = 2'd3
    } pat_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [31:0] word;   // 32 generated bits, first bit in [31]
        logic [30:0] state;  // LFSR state after the 32 steps
    } lane_step_t;

    function automatic lane_step_t prbs7_step32(input logic [6:0] seed);
        logic [6:0] s;
        logic       nb;
        lane_step_t r;
        s = seed;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            nb = s[6] ^ s[5];
            s = {s[5:0], nb};
            r.word[31-k] = nb;
        end
        r.state = {24'd0, s};
        return r;
    endfunction

    function automatic lane_step_t prbs31_step32(input logic [30:0] seed);
        logic [30:0] s;
        logic        nb;
        lane_step_t  r;
        s = seed;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            nb = s[30] ^ s[27];
            s = {s[29:0], nb};
            r.word[31-k] = nb;
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/stream_pattern_lane.sv
// -----------------------------------------------------------------------------
// stream_pattern_lane
// One 32-bit lane of the pattern generator. It holds the lane state and the
// registered output word.
//   clk, aresetn : clock, asynchronous active-low reset
//   load         : take the seed and register beat 0 of a new run
//   advance      : current beat accepted; register the next beat
//   mode         : pattern to generate (already latched by the top)
//   seed         : run seed (before per-lane XOR / zero sanitising)
//   data         : registered lane word
// Per mode, state_q holds the beat index n (counter), the LFSR state (PRBS)
// or the lane seed (fixed).
// -----------------------------------------------------------------------------
module stream_pattern_lane
    import stream_pattern_pkg::*;
#(
    parameter int LANE_IDX      = 0,
    parameter bit LANE_SEED_XOR = 1'b1
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        load,
    input  logic        advance,
    input  pat_mode_t   mode,
    input  logic [31:0] seed,
    output logic [31:0] data
);

    localparam logic [7:0] LANE_ID = 8'(LANE_IDX);

    logic [31:0] state_q;
    logic [31:0] lane_seed;
    logic [31:0] src;
    logic [6:0]  src7;
    logic [30:0] src31;
    logic [23:0] idx;
    lane_step_t  s7;
    lane_step_t  s31;
    logic [31:0] next_word;
    logic [31:0] next_state;

    assign lane_seed = LANE_SEED_XOR ? (seed ^ 32'(LANE_IDX)) : seed;

    always_comb begin
        src   = load ? lane_seed : state_q;
        src7  = src[6:0];
        src31 = src[30:0];
        // An all-zero LFSR seed would lock up; substitute 1 at load time.
        if (load && (src7 == 7'd0)) src7 = 7'd1;
        if (load && (src31 == 31'd0)) src31 = 31'd1;
        s7  = prbs7_step32(src7);
        s31 = prbs31_step32(src31);
        idx = load ? 24'd0 : state_q[23:0];
        next_word  = src;
        next_state = src;
        case (mode)
            PAT_COUNTER: begin
                next_word  = {LANE_ID, idx};
                next_state = {8'd0, idx + 24'd1};
            end
            PAT_PRBS7: begin
                next_word  = s7.word;
                next_state = {1'b0, s7.state};
            end
            PAT_PRBS31: begin
                next_word  = s31.word;
                next_state = {1'b0, s31.state};
            end
            default: begin
                next_word  = src;
                next_state = src;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= '0;
            data    <= '0;
        end else if (load || advance) begin
            state_q <= next_state;
            data    <= next_word;
        end
    end

endmodule

// File: rtl/stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// stream_pattern_gen
// Deterministic AXIS reference source: a per-lane counter, PRBS7, PRBS31 or a
// fixed word, on TDATA_WIDTH/32 independent lanes.
//   clk, aresetn      : stream clock, asynchronous active-low reset
//   cfg_start         : pulse, latch mode/seed/burst length and begin a run
//   cfg_stop          : pulse, finish the run once the current beat is taken
//   cfg_mode          : 0 counter, 1 PRBS7, 2 PRBS31, 3 fixed
//   cfg_seed          : lane seed (XOR lane index when LANE_SEED_XOR=1)
//   cfg_burst_len     : beats per run, 0 = continuous
//   cfg_inject_err    : pulse, flip lane0 bit0 of the next accepted beat
//   M_AXIS_TDATA/TVALID/TREADY : AXIS master
//   busy              : high in RUN or DRAIN
//   beat_count        : beats accepted in the current/last run
// Optional build macro STREAM_PATTERN_GEN_ERR_INJECT_EN enables error injection;
// without it cfg_inject_err is ignored.
// Handshake: a beat transfers on a rising edge where TVALID and TREADY are both
// high. While TVALID is high and TREADY is low, TDATA and all state are held.
// -----------------------------------------------------------------------------
module stream_pattern_gen
    import stream_pattern_pkg::*;
#(
    parameter int TDATA_WIDTH   = 32,
    parameter bit LANE_SEED_XOR = 1'b1
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [1:0]             cfg_mode,
    input  logic [31:0]            cfg_seed,
    input  logic [31:0]            cfg_burst_len,
    input  logic                   cfg_inject_err,
    output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   busy,
    output logic [31:0]            beat_count
);

    localparam int NLINKS = TDATA_WIDTH / 32;

    fsm_state_t             state;
    pat_mode_t              mode_q;
    pat_mode_t              lane_mode;
    logic [31:0]            burst_q;
    logic [31:0]            next_count;
    logic                   accept;
    logic                   load;
    logic                   burst_done;
    logic [TDATA_WIDTH-1:0] pattern;

    assign accept     = M_AXIS_TVALID & M_AXIS_TREADY;
    assign load       = (state == ST_IDLE) && cfg_start;
    assign lane_mode  = load ? pat_mode_t'(cfg_mode) : mode_q;
    assign next_count = beat_count + 32'd1;
    assign burst_done = (burst_q != 32'd0) && (next_count == burst_q);

    for (genvar i = 0; i < NLINKS; i++) begin : g_lane
        stream_pattern_lane #(
            .LANE_IDX      (i),
            .LANE_SEED_XOR (LANE_SEED_XOR)
        ) u_lane (
            .clk     (clk),
            .aresetn (aresetn),
            .load    (load),
            .advance (accept),
            .mode    (lane_mode),
            .seed    (cfg_seed),
            .data    (pattern[i*32 +: 32])
        );
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            M_AXIS_TVALID <= 1'b0;
            busy          <= 1'b0;
            beat_count    <= '0;
            mode_q        <= PAT_COUNTER;
            burst_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Start beats a simultaneous stop.
                    if (cfg_start) begin
                        state         <= ST_RUN;
                        M_AXIS_TVALID <= 1'b1;
                        busy          <= 1'b1;
                        beat_count    <= '0;
                        mode_q        <= pat_mode_t'(cfg_mode);
                        burst_q       <= cfg_burst_len;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        beat_count <= next_count;
                    end
                    if (accept && (burst_done || cfg_stop)) begin
                        // The last beat has gone; nothing left to drain.
                        state         <= ST_IDLE;
                        M_AXIS_TVALID <= 1'b0;
                        busy          <= 1'b0;
                    end else if (cfg_stop) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        beat_count    <= next_count;
                        state         <= ST_IDLE;
                        M_AXIS_TVALID <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    M_AXIS_TVALID <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    // The flag corrupts only the presented word, never the lane state.
    // Later beats are therefore clean.
    logic inject_armed;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            inject_armed <= 1'b0;
        end else begin
            inject_armed <= cfg_inject_err | (inject_armed & ~accept);
        end
    end

    assign M_AXIS_TDATA = pattern ^ {{(TDATA_WIDTH-1){1'b0}}, inject_armed};
`else
    logic unused_inject;
    assign unused_inject = cfg_inject_err;
    assign M_AXIS_TDATA  = pattern;
`endif

endmodule

// File: tb/tb_stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_stream_pattern_gen
// Bench for stream_pattern_gen with two lanes (TDATA_WIDTH=64), LANE_SEED_XOR=0.
// A table of burst runs is checked against hand-computed first/last words.
// Directed sequences cover backpressure, PRBS streams, stop/drain,
// start/stop priority, error injection and mid-run reset.
// In the PRBS streams, each accepted beat is checked against a software
// bit-history LFSR model.
// -----------------------------------------------------------------------------
module tb_stream_pattern_gen;
    import stream_pattern_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_stop = 1'b0;
    logic [1:0]   cfg_mode = 2'd0;
    logic [31:0]  cfg_seed = '0;
    logic [31:0]  cfg_burst_len = '0;
    logic         cfg_inject_err = 1'b0;
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready = 1'b0;
    logic         busy;
    logic [31:0]  beat_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] seen[0:1023];

    typedef struct {
        logic [1:0]   mode;
        logic [31:0]  seed;
        logic [31:0]  burst;
        logic [W-1:0] first;
        logic [W-1:0] last;
    } vec_t;

    vec_t vecs[6];

    stream_pattern_gen #(
        .TDATA_WIDTH   (W),
        .LANE_SEED_XOR (1'b0)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_mode       (cfg_mode),
        .cfg_seed       (cfg_seed),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_inject_err (cfg_inject_err),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TREADY  (tready),
        .busy           (busy),
        .beat_count     (beat_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // helpers
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] cnt_word(input int n);
        logic [23:0] m;
        m = n[23:0];
        return {8'h01, m, 8'h00, m};
    endfunction

    // Model: b[n] = b[n-order] ^ b[n-tap2], with seed 1 as the latest history bit.
    task automatic build_prbs(input int order, input int nbeats);
        bit          bh[$];
        bit          nb;
        int          tb2;
        logic [31:0] w;
        tb2 = (order == 7) ? 6 : 28;
        for (int i = 0; i < order - 1; i++) bh.push_back(1'b0);
        bh.push_back(1'b1);
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < 32; k++) begin
                nb = bh[bh.size() - order] ^ bh[bh.size() - tb2];
                bh.push_back(nb);
                w[31-k] = nb;
                if (bh.size() > 64) void'(bh.pop_front());
            end
            exp_q.push_back({w, w});
        end
    endtask

    // drivers
    task automatic start_run(input logic [1:0] mode, input logic [31:0] seed,
                             input logic [31:0] burst, input logic with_stop);
        cfg_mode      = mode;
        cfg_seed      = seed;
        cfg_burst_len = burst;
        cfg_start     = 1'b1;
        cfg_stop      = with_stop;
        cycle();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
    endtask

    // Consume beats until TVALID drops. Optionally stall on a beat and check it.
    task automatic run_stream(input bit use_sb, input int stall_beat, input int stall_len,
                              input int max_cycles, output int nbeats);
        int           cyc;
        int           stalls;
        logic [W-1:0] held;
        cyc    = 0;
        stalls = 0;
        nbeats = 0;
        held   = '0;
        while (tvalid && (cyc < max_cycles)) begin
            if ((nbeats == stall_beat) && (stalls < stall_len)) begin
                tready = 1'b0;
                if (stalls == 0) held = tdata;
                else check("stall_data", tdata, held);
                check("stall_count", W'(beat_count), W'(nbeats));
                stalls++;
            end else begin
                tready = 1'b1;
                if (nbeats < 1024) seen[nbeats] = tdata;
                if (use_sb) begin
                    if (exp_q.size() == 0) check("sb_extra_beat", tdata, ~tdata);
                    else check("sb_beat", tdata, exp_q.pop_front());
                end
                nbeats++;
            end
            cycle();
            cyc++;
        end
        tready = 1'b0;
        if (tvalid) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: TVALID still high after %0d cycles", max_cycles);
        end
        if (use_sb) check("sb_left", W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    // test
    initial begin
        int           n;
        logic [W-1:0] e;

        vecs[0] = '{2'd0, 32'h0,        32'd4,   64'h01000000_00000000, 64'h01000003_00000003};
        vecs[1] = '{2'd0, 32'h0,        32'd1,   64'h01000000_00000000, 64'h01000000_00000000};
        vecs[2] = '{2'd3, 32'hDEADBEEF, 32'd3,   64'hDEADBEEF_DEADBEEF, 64'hDEADBEEF_DEADBEEF};
        vecs[3] = '{2'd3, 32'h0,        32'd2,   64'h0,                 64'h0};
        vecs[4] = '{2'd0, 32'h55,       32'd300, 64'h01000000_00000000, 64'h0100012B_0000012B};
        vecs[5] = '{2'd1, 32'h0,        32'd1,   64'h06147916_06147916, 64'h06147916_06147916};

        // Reset values.
        aresetn = 1'b0;
        repeat (3) cycle();
        check("rst_tvalid", W'(tvalid), '0);
        check("rst_tdata", tdata, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_beat_count", W'(beat_count), '0);
        aresetn = 1'b1;
        cycle();

        // Table of burst runs with TREADY held high.
        for (int i = 0; i < 6; i++) begin
            start_run(vecs[i].mode, vecs[i].seed, vecs[i].burst, 1'b0);
            check("tbl_first_valid", W'(tvalid), W'(1));
            check("tbl_busy_run", W'(busy), W'(1));
            run_stream(1'b0, -1, 0, 2000, n);
            check("tbl_nbeats", W'(n), W'(vecs[i].burst));
            check("tbl_first", seen[0], vecs[i].first);
            check("tbl_last", seen[(n > 0) ? n - 1 : 0], vecs[i].last);
            check("tbl_beat_count", W'(beat_count), W'(vecs[i].burst));
            check("tbl_busy_end", W'(busy), '0);
            cycle();
        end

        // Backpressure: 3 stalled cycles on beat 2.
        for (int i = 0; i < 6; i++) exp_q.push_back(cnt_word(i));
        start_run(2'd0, 32'h0, 32'd6, 1'b0);
        run_stream(1'b1, 2, 3, 100, n);
        check("bp_nbeats", W'(n), W'(6));
        check("bp_beat_count", W'(beat_count), W'(6));
        cycle();

        // PRBS31 against the model over 1000 beats.
        build_prbs(31, 1000);
        start_run(2'd2, 32'h0, 32'd1000, 1'b0);
        run_stream(1'b1, -1, 0, 3000, n);
        check("prbs31_nbeats", W'(n), W'(1000));
        cycle();

        // PRBS7 over 128 beats; the sequence repeats after 127 words.
        build_prbs(7, 128);
        start_run(2'd1, 32'h0, 32'd128, 1'b0);
        run_stream(1'b1, -1, 0, 500, n);
        check("prbs7_period", seen[127], seen[0]);
        cycle();

        // Continuous run: start during RUN is ignored; stop while stalled drains.
        start_run(2'd0, 32'h0, 32'd0, 1'b0);
        tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_start = (i == 2);
            cycle();
        end
        cfg_start = 1'b0;
        check("cont_beat_count", W'(beat_count), W'(5));
        check("cont_tdata", tdata, cnt_word(5));
        tready   = 1'b0;
        cfg_stop = 1'b1;
        cycle();
        cfg_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_tvalid", W'(tvalid), W'(1));
            check("drain_tdata", tdata, cnt_word(5));
            check("drain_busy", W'(busy), W'(1));
            cycle();
        end
        tready = 1'b1;
        cycle();
        tready = 1'b0;
        check("drain_done_tvalid", W'(tvalid), '0);
        check("drain_done_busy", W'(busy), '0);
        check("drain_done_count", W'(beat_count), W'(6));
        cycle();

        // Start and stop together from IDLE: start wins.
        exp_q.push_back(cnt_word(0));
        exp_q.push_back(cnt_word(1));
        start_run(2'd0, 32'h0, 32'd2, 1'b1);
        check("startstop_busy", W'(busy), W'(1));
        check("startstop_tvalid", W'(tvalid), W'(1));
        run_stream(1'b1, -1, 0, 50, n);
        check("startstop_nbeats", W'(n), W'(2));
        cycle();

        // Inject pulse while beat 4 is accepted; beat 5 carries the flip.
        for (int i = 0; i < 8; i++) begin
            e = cnt_word(i);
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
            if (i == 5) e[0] = ~e[0];
`endif
            exp_q.push_back(e);
        end
        start_run(2'd0, 32'h0, 32'd8, 1'b0);
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cfg_inject_err = (i == 4);
            check("inject_beat", tdata, exp_q.pop_front());
            cycle();
        end
        cfg_inject_err = 1'b0;
        tready = 1'b0;
        check("inject_end_tvalid", W'(tvalid), '0);
        cycle();

        // Reset in the middle of a run.
        start_run(2'd0, 32'h0, 32'd0, 1'b0);
        tready = 1'b1;
        repeat (3) cycle();
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", W'(tvalid), '0);
        check("midrst_tdata", tdata, '0);
        check("midrst_busy", W'(busy), '0);
        check("midrst_beat_count", W'(beat_count), '0);
        tready = 1'b0;
        cycle();
        aresetn = 1'b1;
        cycle();
        check("postrst_tvalid", W'(tvalid), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
